// File: rtl/irq_controller.sv
// Interrupt controller in front of the core's irq/iack pins: edge-detected pending
// sources, per-source mask, global enable, and an ack/EOI handshake with a CAUSE register.
module irq_controller #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             irq,
  input  logic             iack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   src_q, src_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic               en_q, en_d;
  logic               irq_q, irq_d;
  logic               cause_valid_q, cause_valid_d;
  logic [IDX_W-1:0]   cause_idx_q, cause_idx_d;

  logic [N_SRC-1:0]   src_rise;
  logic [N_SRC-1:0]   active;
  logic [N_SRC-1:0]   active_low1h;
  logic               any_active;
  logic [IDX_W-1:0]   sel_idx;
  logic               wr_pend, wr_mask, wr_cause, wr_ctrl;
  logic               unused_wd;

  assign unused_wd = ^wd[31:N_SRC];

  assign src_rise     = src & ~src_q;
  assign active       = pend_q & mask_q;
  assign any_active   = |active;
  // Isolate the lowest set bit, i.e. the highest-priority active source.
  assign active_low1h = active & (~active + N_SRC'(1));

  assign wr_pend  = sel && we && (addr == 2'd0);
  assign wr_mask  = sel && we && (addr == 2'd1);
  assign wr_cause = sel && we && (addr == 2'd2);
  assign wr_ctrl  = sel && we && (addr == 2'd3);

  always_comb begin
    sel_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src;
    mask_d        = wr_mask ? wd[N_SRC-1:0] : mask_q;
    en_d          = wr_ctrl ? wd[0] : en_q;
    cause_valid_d = cause_valid_q;
    cause_idx_d   = cause_idx_q;

    // New edges beat a same-cycle W1C; the ack clear below beats both.
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~wd[N_SRC-1:0];
    pend_d = pend_d | src_rise;

    case (state_q)
      IDLE: begin
        if (en_q && any_active) state_d = REQ;
      end
      REQ: begin
        if (iack && any_active) begin
          cause_valid_d = 1'b1;
          cause_idx_d   = sel_idx;
          pend_d        = pend_d & ~active_low1h;
          state_d       = SERV;
        end else if (iack) begin
          cause_valid_d = 1'b0;
          cause_idx_d   = '0;
          state_d       = SERV;
        end else if (!en_q || !any_active) begin
          state_d = IDLE;
        end
      end
      SERV: begin
        if (wr_cause) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    irq_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      src_q         <= '0;
      pend_q        <= '0;
      mask_q        <= '0;
      en_q          <= 1'b0;
      irq_q         <= 1'b0;
      cause_valid_q <= 1'b0;
      cause_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      en_q          <= en_d;
      irq_q         <= irq_d;
      cause_valid_q <= cause_valid_d;
      cause_idx_q   <= cause_idx_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    case (addr)
      2'd0:    rd = 32'(pend_q);
      2'd1:    rd = 32'(mask_q);
      2'd2:    rd = {cause_valid_q, {(31-IDX_W){1'b0}}, cause_idx_q};
      default: rd = {31'b0, en_q};
    endcase
  end

endmodule
